pipelined_shifter: RTL and testbench



---
 rtl/pipelined_shifter_if.sv | 27 ++
 rtl/pipelined_shifter.sv | 179 +++++++++++++++++
 tb/tb_pipelined_shifter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// Handshake and data bundle for the pipelined barrel shifter.
// The shifter itself takes the slave view; whoever feeds and drains it takes the master view.
interface pipelined_shifter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_mode;
    logic [SHIFT_WIDTH-1:0] in_shift_amt;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_carry;
    logic                   out_zero;

    modport master (
        output in_valid, in_mode, in_shift_amt, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_mode, in_shift_amt, in_data, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined log2 barrel shifter: LSL/LSR/ROL/ROR/ASR with carry and zero flags.
// The operand travels as a DATA_WIDTH+1 bit word whose spare bit catches the last
// bit shifted out: the spare bit sits above the data for left-going and pass-through
// modes and below the data for right shifts, so plain shifts of the whole word leave
// the carry in that bit. Rotates ignore it and take carry from the result instead.
module pipelined_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
    parameter int STAGES      = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_shifter_if.slave bus
);
    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ROL = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ASR = 3'b100;

    // Earlier stages absorb the leftover mux levels when the split is uneven.
    localparam int LVL_BASE  = SHIFT_WIDTH / STAGES;
    localparam int LVL_EXTRA = SHIFT_WIDTH % STAGES;

    function automatic int lvl_lo(input int i);
        return i * LVL_BASE + ((i < LVL_EXTRA) ? i : LVL_EXTRA);
    endfunction

    function automatic int lvl_cnt(input int i);
        return LVL_BASE + ((i < LVL_EXTRA) ? 1 : 0);
    endfunction

    function automatic logic is_right(input logic [2:0] m);
        return (m == MODE_LSR) || (m == MODE_ASR);
    endfunction

    // One mux level of the network: shift/rotate by 2**k.
    function automatic logic [DATA_WIDTH:0] shift_level(
        input logic [DATA_WIDTH:0] e,
        input logic [2:0]          m,
        input int                  k
    );
        logic [DATA_WIDTH:0]   r;
        logic [DATA_WIDTH-1:0] d;
        int                    s;
        s = 1 << k;
        d = e[DATA_WIDTH-1:0];
        r = e;
        case (m)
            MODE_LSL: r = e << s;
            MODE_LSR: r = e >> s;
            MODE_ASR: r = $signed(e) >>> s;
            MODE_ROL: r = {1'b0, (d << s) | (d >> (DATA_WIDTH - s))};
            MODE_ROR: r = {1'b0, (d >> s) | (d << (DATA_WIDTH - s))};
            default:  r = e;
        endcase
        return r;
    endfunction

    // Applies the contiguous block of levels [lo, lo+cnt) owned by one stage.
    function automatic logic [DATA_WIDTH:0] apply_levels(
        input logic [DATA_WIDTH:0]  e,
        input logic [2:0]           m,
        input logic [SHIFT_WIDTH-1:0] a,
        input int                   lo,
        input int                   cnt
    );
        logic [DATA_WIDTH:0] r;
        r = e;
        for (int k = 0; k < SHIFT_WIDTH; k++) begin
            if (k >= lo && k < lo + cnt && a[k]) begin
                r = shift_level(r, m, k);
            end
        end
        return r;
    endfunction

    logic [DATA_WIDTH:0]    st_ext  [STAGES];
    logic [2:0]             st_mode [STAGES];
    logic [SHIFT_WIDTH-1:0] st_amt  [STAGES];
    logic                   st_nz   [STAGES];
    logic                   st_v    [STAGES];

    logic [DATA_WIDTH:0]    nx_ext  [STAGES];
    logic [2:0]             nx_mode [STAGES];
    logic [SHIFT_WIDTH-1:0] nx_amt  [STAGES];
    logic                   nx_nz   [STAGES];
    logic                   nx_v    [STAGES];

    logic [DATA_WIDTH:0]    p_ext;
    logic [2:0]             p_mode;
    logic [SHIFT_WIDTH-1:0] p_amt;
    logic                   p_nz;
    logic                   p_v;

    logic [DATA_WIDTH-1:0]  fin_data;
    logic                   fin_carry;
    logic                   fin_zero;
    logic [DATA_WIDTH:0]    fin_ext;
    logic [2:0]             fin_mode;

    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_carry_q;
    logic                   out_zero_q;
    logic                   adv;

    // Single global stall: everything moves when the output slot is free or being drained.
    assign adv           = !st_v[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = st_v[STAGES-1];
    assign bus.out_data  = out_data_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_zero  = out_zero_q;

    // Next-state of every stage: each stage runs its own levels on the previous stage's register.
    always_comb begin
        p_ext  = is_right(bus.in_mode) ? {bus.in_data, 1'b0} : {1'b0, bus.in_data};
        p_mode = bus.in_mode;
        p_amt  = bus.in_shift_amt;
        p_nz   = |bus.in_shift_amt;
        p_v    = bus.in_valid;
        for (int i = 0; i < STAGES; i++) begin
            nx_ext[i]  = apply_levels(p_ext, p_mode, p_amt, lvl_lo(i), lvl_cnt(i));
            nx_mode[i] = p_mode;
            nx_amt[i]  = p_amt;
            nx_nz[i]   = p_nz;
            nx_v[i]    = p_v;
            p_ext      = st_ext[i];
            p_mode     = st_mode[i];
            p_amt      = st_amt[i];
            p_nz       = st_nz[i];
            p_v        = st_v[i];
        end
    end

    // Final-stage result extraction and flags; registered alongside the data.
    always_comb begin
        fin_ext   = nx_ext[STAGES-1];
        fin_mode  = nx_mode[STAGES-1];
        fin_data  = is_right(fin_mode) ? fin_ext[DATA_WIDTH:1] : fin_ext[DATA_WIDTH-1:0];
        fin_carry = 1'b0;
        case (fin_mode)
            MODE_LSL: fin_carry = fin_ext[DATA_WIDTH];
            MODE_LSR,
            MODE_ASR: fin_carry = fin_ext[0];
            MODE_ROL: fin_carry = nx_nz[STAGES-1] & fin_data[0];
            MODE_ROR: fin_carry = nx_nz[STAGES-1] & fin_data[DATA_WIDTH-1];
            default:  fin_carry = 1'b0;
        endcase
        fin_zero = (fin_data == '0);
    end

    // Pipeline registers: synchronous reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                st_ext[i]  <= '0;
                st_mode[i] <= '0;
                st_amt[i]  <= '0;
                st_nz[i]   <= 1'b0;
                st_v[i]    <= 1'b0;
            end
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                st_ext[i]  <= nx_ext[i];
                st_mode[i] <= nx_mode[i];
                st_amt[i]  <= nx_amt[i];
                st_nz[i]   <= nx_nz[i];
                st_v[i]    <= nx_v[i];
            end
            out_data_q  <= fin_data;
            out_carry_q <= fin_carry;
            out_zero_q  <= fin_zero;
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and randomized bench for pipelined_shifter; three instances with STAGES = 2, 1, 5.
module tb_pipelined_shifter;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    logic        drv_valid [3];
    logic [2:0]  drv_mode  [3];
    logic [4:0]  drv_amt   [3];
    logic [31:0] drv_data  [3];
    logic        drv_ready [3];
    logic        mon_ready [3];
    logic        mon_valid [3];
    logic [31:0] mon_data  [3];
    logic        mon_carry [3];
    logic        mon_zero  [3];

    always #5 clk = ~clk;

    for (genvar u = 0; u < 3; u++) begin : g_unit
        pipelined_shifter_if #(.DATA_WIDTH(32)) bus ();
        pipelined_shifter #(
            .DATA_WIDTH(32),
            .STAGES(u == 0 ? 2 : (u == 1 ? 1 : 5))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        assign bus.in_valid     = drv_valid[u];
        assign bus.in_mode      = drv_mode[u];
        assign bus.in_shift_amt = drv_amt[u];
        assign bus.in_data      = drv_data[u];
        assign bus.out_ready    = drv_ready[u];
        assign mon_ready[u]     = bus.in_ready;
        assign mon_valid[u]     = bus.out_valid;
        assign mon_data[u]      = bus.out_data;
        assign mon_carry[u]     = bus.out_carry;
        assign mon_zero[u]      = bus.out_zero;
    end

    function automatic int stg_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 5);
    endfunction

    // Independent reference: direct bit indexing, no extended-word trick.
    function automatic logic [33:0] model(input logic [2:0] m, input logic [4:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        c;
        int          n;
        n = int'(a);
        r = d;
        c = 1'b0;
        if (n != 0) begin
            case (m)
                3'd0: begin r = d << n; c = d[32-n]; end
                3'd1: begin r = d >> n; c = d[n-1]; end
                3'd2: begin r = (d << n) | (d >> (32 - n)); c = r[0]; end
                3'd3: begin r = (d >> n) | (d << (32 - n)); c = r[31]; end
                3'd4: begin r = $signed(d) >>> n; c = d[n-1]; end
                default: begin r = d; c = 1'b0; end
            endcase
        end
        return {r, c, (r == 32'd0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int u = 0; u < 3; u++) begin
            drv_valid[u] = 1'b0;
            drv_mode[u]  = 3'd0;
            drv_amt[u]   = 5'd0;
            drv_data[u]  = 32'd0;
            drv_ready[u] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            total++;
            if (mon_valid[u] !== 1'b0 || mon_data[u] !== 32'd0 || mon_carry[u] !== 1'b0 || mon_zero[u] !== 1'b0)
                $display("FAIL reset_state u%0d: got v=%b d=%h c=%b z=%b want v=0 d=0 c=0 z=0",
                         u, mon_valid[u], mon_data[u], mon_carry[u], mon_zero[u]);
            else passed++;
        end
        tick();
        for (int u = 0; u < 3; u++) begin
            total++;
            if (mon_ready[u] !== 1'b1) $display("FAIL ready_after_reset u%0d: got %b want 1", u, mon_ready[u]);
            else passed++;
        end
    endtask

    task automatic single_op(input int u, input logic [2:0] m, input logic [4:0] a, input logic [31:0] d,
                             input logic [31:0] ed, input logic ec, input logic ez, input string nm);
        int stg;
        stg = stg_of(u);
        drv_valid[u] = 1'b1;
        drv_mode[u]  = m;
        drv_amt[u]   = a;
        drv_data[u]  = d;
        drv_ready[u] = 1'b1;
        #1;
        total++;
        if (mon_ready[u] !== 1'b1) $display("FAIL %s ready_at_issue: got %b want 1", nm, mon_ready[u]);
        else passed++;
        tick();
        drv_valid[u] = 1'b0;
        drv_mode[u]  = 3'd7;
        drv_amt[u]   = 5'd17;
        drv_data[u]  = 32'hDEAD_BEEF;
        for (int c = 1; c < stg; c++) begin
            #1;
            total++;
            if (mon_valid[u] !== 1'b0) $display("FAIL %s early_valid edge %0d: got %b want 0", nm, c, mon_valid[u]);
            else passed++;
            tick();
        end
        #1;
        total++;
        if (mon_valid[u] !== 1'b1) $display("FAIL %s latency: out_valid got %b want 1", nm, mon_valid[u]);
        else passed++;
        total++;
        if (mon_data[u] !== ed || mon_carry[u] !== ec || mon_zero[u] !== ez)
            $display("FAIL %s result: got d=%h c=%b z=%b want d=%h c=%b z=%b",
                     nm, mon_data[u], mon_carry[u], mon_zero[u], ed, ec, ez);
        else passed++;
        tick();
        total++;
        if (mon_valid[u] !== 1'b0) $display("FAIL %s drain: out_valid got %b want 0", nm, mon_valid[u]);
        else passed++;
    endtask

    task automatic test_directed();
        single_op(0, 3'd0,  5'd1, 32'h8000_0001, 32'h0000_0002, 1'b1, 1'b0, "lsl_by1");
        single_op(0, 3'd4, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "asr_by31");
        single_op(0, 3'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, "lsr_by31");
        single_op(0, 3'd3,  5'd1, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, "ror_by1");
        single_op(0, 3'd2,  5'd4, 32'h8000_0000, 32'h0000_0008, 1'b0, 1'b0, "rol_by4");
        single_op(0, 3'd1,  5'd1, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, "lsr_to_zero");
        single_op(0, 3'd2,  5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 1'b0, "rol_amt0");
        single_op(0, 3'd6,  5'd9, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, "mode110");
        single_op(0, 3'd0,  5'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, "lsl_amt0_zero");
        single_op(0, 3'd4,  5'd4, 32'h8000_00F8, 32'hF800_000F, 1'b1, 1'b0, "asr_by4");
        single_op(0, 3'd0, 5'd31, 32'h0000_0003, 32'h8000_0000, 1'b1, 1'b0, "lsl_by31");
    endtask

    task automatic test_latency();
        single_op(1, 3'd0, 5'd1, 32'h8000_0001, 32'h0000_0002, 1'b1, 1'b0, "s1_lsl_by1");
        single_op(2, 3'd2, 5'd4, 32'h8000_0000, 32'h0000_0008, 1'b0, 1'b0, "s5_rol_by4");
        single_op(2, 3'd3, 5'd31, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, "s5_ror_by31");
    endtask

    task automatic test_backpressure();
        logic [2:0]  tm [6];
        logic [4:0]  ta [6];
        logic [31:0] td [6];
        logic [31:0] te [6];
        logic        tc [6];
        int          iss, rcv, stall_left, stalls_seen, cyc;
        logic        first_seen, acc_in, acc_out;
        tm[0] = 3'd0; ta[0] = 5'd4; td[0] = 32'h0000_00FF; te[0] = 32'h0000_0FF0; tc[0] = 1'b0;
        tm[1] = 3'd1; ta[1] = 5'd4; td[1] = 32'h0000_00FF; te[1] = 32'h0000_000F; tc[1] = 1'b1;
        tm[2] = 3'd2; ta[2] = 5'd8; td[2] = 32'h1234_5678; te[2] = 32'h3456_7812; tc[2] = 1'b0;
        tm[3] = 3'd3; ta[3] = 5'd8; td[3] = 32'h1234_5678; te[3] = 32'h7812_3456; tc[3] = 1'b0;
        tm[4] = 3'd4; ta[4] = 5'd28; td[4] = 32'hF000_0000; te[4] = 32'hFFFF_FFFF; tc[4] = 1'b0;
        tm[5] = 3'd3; ta[5] = 5'd1; td[5] = 32'h0000_0003; te[5] = 32'h8000_0001; tc[5] = 1'b1;
        iss = 0; rcv = 0; stall_left = 0; stalls_seen = 0; cyc = 0; first_seen = 1'b0;
        while ((iss < 6 || rcv < 6) && cyc < 40) begin
            drv_valid[0] = (iss < 6);
            if (iss < 6) begin
                drv_mode[0] = tm[iss]; drv_amt[0] = ta[iss]; drv_data[0] = td[iss];
            end else begin
                drv_mode[0] = 3'd5; drv_amt[0] = 5'd3; drv_data[0] = 32'hCAFE_F00D;
            end
            if (mon_valid[0] && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                drv_ready[0] = 1'b0;
                stall_left--;
            end else begin
                drv_ready[0] = 1'b1;
            end
            #1;
            total++;
            if (mon_ready[0] !== (!mon_valid[0] || drv_ready[0]))
                $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, mon_ready[0], !mon_valid[0] || drv_ready[0]);
            else passed++;
            if (mon_valid[0] && !drv_ready[0]) stalls_seen++;
            if (mon_valid[0]) begin
                total++;
                if (rcv >= 6)
                    $display("FAIL bp_extra_result cyc %0d: got d=%h want no result", cyc, mon_data[0]);
                else if (mon_data[0] !== te[rcv] || mon_carry[0] !== tc[rcv] || mon_zero[0] !== 1'b0)
                    $display("FAIL bp_result %0d: got d=%h c=%b z=%b want d=%h c=%b z=0",
                             rcv, mon_data[0], mon_carry[0], mon_zero[0], te[rcv], tc[rcv]);
                else passed++;
            end
            acc_in  = drv_valid[0] && mon_ready[0];
            acc_out = mon_valid[0] && drv_ready[0];
            tick();
            cyc++;
            if (acc_in) iss++;
            if (acc_out) rcv++;
        end
        total++;
        if (iss != 6 || rcv != 6) $display("FAIL bp_count: got issued=%0d received=%0d want 6/6", iss, rcv);
        else passed++;
        total++;
        if (stalls_seen != 3) $display("FAIL bp_stall_cycles: got %0d want 3", stalls_seen);
        else passed++;
        drv_valid[0] = 1'b0;
        drv_ready[0] = 1'b1;
        tick();
        tick();
        total++;
        if (mon_valid[0] !== 1'b0) $display("FAIL bp_no_duplicate: out_valid got %b want 0", mon_valid[0]);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        logic seen;
        drv_ready[0] = 1'b0;
        drv_valid[0] = 1'b1; drv_mode[0] = 3'd0; drv_amt[0] = 5'd1; drv_data[0] = 32'h0000_0011;
        tick();
        drv_mode[0] = 3'd1; drv_amt[0] = 5'd2; drv_data[0] = 32'h0000_0400;
        tick();
        drv_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (mon_valid[0] !== 1'b1) $display("FAIL rst_mid_setup: out_valid got %b want 1", mon_valid[0]);
        else passed++;
        tick();
        rst = 1'b0;
        drv_ready[0] = 1'b1;
        #1;
        total++;
        if (mon_valid[0] !== 1'b0 || mon_data[0] !== 32'd0)
            $display("FAIL rst_mid_flush: got v=%b d=%h want v=0 d=0", mon_valid[0], mon_data[0]);
        else passed++;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            seen = seen | mon_valid[0];
        end
        total++;
        if (seen !== 1'b0) $display("FAIL rst_mid_ghost: stale result seen=%b want 0", seen);
        else passed++;
    endtask

    task automatic test_random(input int u, input int nops, input int rst_cycle);
        logic [33:0] q[$];
        logic [33:0] e;
        int          issued, cyc;
        logic        acc_in, acc_out, in_rst, after_rst;
        issued = 0; cyc = 0; after_rst = 1'b0;
        while ((issued < nops || q.size() > 0) && cyc < 2000) begin
            in_rst = (cyc == rst_cycle);
            rst    = in_rst;
            drv_ready[u] = ($urandom_range(0, 3) != 0);
            drv_mode[u]  = 3'($urandom_range(0, 7));
            drv_amt[u]   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            drv_data[u]  = $urandom;
            drv_valid[u] = !in_rst && (issued < nops) && ($urandom_range(0, 3) != 0);
            #1;
            acc_in = 1'b0;
            acc_out = 1'b0;
            if (!in_rst) begin
                if (after_rst) begin
                    total++;
                    if (mon_valid[u] !== 1'b0 || mon_ready[u] !== 1'b1)
                        $display("FAIL rnd_u%0d post_reset: got v=%b rdy=%b want v=0 rdy=1", u, mon_valid[u], mon_ready[u]);
                    else passed++;
                end
                total++;
                if (mon_ready[u] !== (!mon_valid[u] || drv_ready[u]))
                    $display("FAIL rnd_u%0d in_ready cyc %0d: got %b want %b", u, cyc, mon_ready[u], !mon_valid[u] || drv_ready[u]);
                else passed++;
                if (mon_valid[u]) begin
                    total++;
                    if (q.size() == 0) begin
                        $display("FAIL rnd_u%0d phantom cyc %0d: got d=%h want no result", u, cyc, mon_data[u]);
                    end else begin
                        e = q[0];
                        if ({mon_data[u], mon_carry[u], mon_zero[u]} !== e)
                            $display("FAIL rnd_u%0d result cyc %0d: got d=%h c=%b z=%b want d=%h c=%b z=%b",
                                     u, cyc, mon_data[u], mon_carry[u], mon_zero[u], e[33:2], e[1], e[0]);
                        else passed++;
                    end
                end
                acc_in  = drv_valid[u] && mon_ready[u];
                acc_out = mon_valid[u] && drv_ready[u];
                if (acc_in) q.push_back(model(drv_mode[u], drv_amt[u], drv_data[u]));
            end
            tick();
            cyc++;
            after_rst = in_rst;
            if (in_rst) q.delete();
            if (acc_in) issued++;
            if (acc_out && q.size() > 0) void'(q.pop_front());
        end
        rst = 1'b0;
        drv_valid[u] = 1'b0;
        drv_ready[u] = 1'b1;
        total++;
        if (issued != nops || q.size() != 0)
            $display("FAIL rnd_u%0d completion: got issued=%0d pending=%0d want %0d/0", u, issued, q.size(), nops);
        else passed++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_backpressure();
        test_reset_midstream();
        test_random(1, 40, 30);
        test_random(2, 40, 35);
        test_random(0, 30, 20);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
